// File: rtl/cache_level_ctrl.sv
// cache_level_ctrl: one level of a set-associative, tag-only cache hierarchy.
// Takes requests over a valid/ready handshake, does a one-cycle tag lookup,
// and services misses, write-throughs and dirty writebacks over the nl_*
// handshake. Keeps saturating hit/miss/read/write/writeback statistics.
// Optional build macro: CACHE_FLUSH_EN adds flush_req/flush_done and a
// full-array flush walk that writes back dirty lines and invalidates all.
module cache_level_ctrl #(
    parameter int ADDR_W      = 48,
    parameter int NUM_SETS    = 64,
    parameter int ASSOC       = 4,
    parameter int BLOCK_BYTES = 64,
    parameter int CNT_W       = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_policy,
    input  logic              replace_policy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_op,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              nl_valid,
    input  logic              nl_ready,
    output logic [ADDR_W-1:0] nl_addr,
    output logic              nl_write,
    output logic [CNT_W-1:0]  reads,
    output logic [CNT_W-1:0]  writes,
    output logic [CNT_W-1:0]  hits,
    output logic [CNT_W-1:0]  misses,
    output logic [CNT_W-1:0]  writebacks
`ifdef CACHE_FLUSH_EN
    ,
    input  logic              flush_req,
    output logic              flush_done
`endif
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int AGE_W = WAY_W;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ASSOC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_WT,
        S_RESP
`ifdef CACHE_FLUSH_EN
        ,
        S_FLUSH,
        S_FLUSH_WB,
        S_FLUSH_DONE
`endif
    } state_t;

    state_t state, next_state;

    // Line state arrays
    logic [TAG_W-1:0] tag_mem   [NUM_SETS][ASSOC];
    logic [ASSOC-1:0] valid_mem [NUM_SETS];
    logic [ASSOC-1:0] dirty_mem [NUM_SETS];
    logic [AGE_W-1:0] age_mem   [NUM_SETS][ASSOC];

    // Request fields captured at acceptance
    logic [TAG_W-1:0] lat_tag;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_write;
    logic             lat_wp;
    logic             lat_rp;
    logic             lat_hit;
    logic [WAY_W-1:0] lat_way;   // hit way or chosen victim

    logic             accept;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_dirty;
    logic             do_touch;
    logic [WAY_W-1:0] touch_way;
    logic [AGE_W-1:0] touch_ref;

    // Offset bits never reach the tag store; nl_addr is block aligned.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFF_W-1:0];

`ifdef CACHE_FLUSH_EN
    logic [IDX_W-1:0] f_set;
    logic [WAY_W-1:0] f_way;
    logic             f_last;
    logic             f_dirty;
    logic             flush_step;

    assign f_last  = (f_set == IDX_W'(NUM_SETS - 1)) && (f_way == WAY_W'(ASSOC - 1));
    assign f_dirty = valid_mem[f_set][f_way] && dirty_mem[f_set][f_way];
    assign flush_step = ((state == S_FLUSH) && !f_dirty) ||
                        ((state == S_FLUSH_WB) && nl_ready);
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Tag compare across all ways of the latched set
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_mem[lat_idx][w] && (tag_mem[lat_idx][w] == lat_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest invalid way, else the oldest way
    always_comb begin
        logic             have_inv;
        logic [WAY_W-1:0] inv_way;
        logic [WAY_W-1:0] old_way;
        have_inv = 1'b0;
        inv_way  = '0;
        old_way  = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_mem[lat_idx][w]) begin
                have_inv = 1'b1;
                inv_way  = WAY_W'(w);
            end
            if (age_mem[lat_idx][w] == AGE_MAX) begin
                old_way = WAY_W'(w);
            end
        end
        victim_way   = have_inv ? inv_way : old_way;
        victim_dirty = valid_mem[lat_idx][victim_way] && dirty_mem[lat_idx][victim_way];
    end

    // Replacement-state update strobe: LRU hits in LOOKUP, installs in FILL.
    // An invalid way counts as oldest so every live way ages past it.
    always_comb begin
        do_touch  = ((state == S_LOOKUP) && hit_any && lat_rp) ||
                    ((state == S_FILL) && nl_ready);
        touch_way = (state == S_LOOKUP) ? hit_way : lat_way;
        touch_ref = valid_mem[lat_idx][touch_way] ? age_mem[lat_idx][touch_way] : AGE_MAX;
    end

    // FSM state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // FSM next-state and handshake outputs
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        nl_valid   = 1'b0;
        nl_write   = 1'b0;
        nl_addr    = '0;
`ifdef CACHE_FLUSH_EN
        flush_done = 1'b0;
`endif
        case (state)
            S_IDLE: begin
`ifdef CACHE_FLUSH_EN
                req_ready = !flush_req;
                if (flush_req)      next_state = S_FLUSH;
                else if (req_valid) next_state = S_LOOKUP;
`else
                req_ready = 1'b1;
                if (req_valid) next_state = S_LOOKUP;
`endif
            end
            S_LOOKUP: begin
                if (lat_write && !lat_wp) next_state = S_WT;
                else if (hit_any)         next_state = S_RESP;
                else if (victim_dirty)    next_state = S_WB;
                else                      next_state = S_FILL;
            end
            S_WB: begin
                nl_valid = 1'b1;
                nl_write = 1'b1;
                nl_addr  = {tag_mem[lat_idx][lat_way], lat_idx, {OFF_W{1'b0}}};
                if (nl_ready) next_state = S_FILL;
            end
            S_FILL: begin
                nl_valid = 1'b1;
                nl_addr  = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                if (nl_ready) next_state = S_RESP;
            end
            S_WT: begin
                nl_valid = 1'b1;
                nl_write = 1'b1;
                nl_addr  = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                if (nl_ready) next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = lat_hit;
                next_state = S_IDLE;
            end
`ifdef CACHE_FLUSH_EN
            S_FLUSH: begin
                if (f_dirty)     next_state = S_FLUSH_WB;
                else if (f_last) next_state = S_FLUSH_DONE;
            end
            S_FLUSH_WB: begin
                nl_valid = 1'b1;
                nl_write = 1'b1;
                nl_addr  = {tag_mem[f_set][f_way], f_set, {OFF_W{1'b0}}};
                if (nl_ready) next_state = f_last ? S_FLUSH_DONE : S_FLUSH;
            end
            S_FLUSH_DONE: begin
                flush_done = 1'b1;
                next_state = S_IDLE;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid && req_ready;

    // Tag store written on install
    // NOTE: tags carry no reset; a tag is only ever compared behind its valid bit.
    always_ff @(posedge clk) begin
        if ((state == S_FILL) && nl_ready) tag_mem[lat_idx][lat_way] <= lat_tag;
    end

    // Request latch, line state, replacement ages and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < ASSOC; w++) age_mem[s][w] <= '0;
            end
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_write  <= 1'b0;
            lat_wp     <= 1'b0;
            lat_rp     <= 1'b0;
            lat_hit    <= 1'b0;
            lat_way    <= '0;
            reads      <= '0;
            writes     <= '0;
            hits       <= '0;
            misses     <= '0;
            writebacks <= '0;
`ifdef CACHE_FLUSH_EN
            f_set      <= '0;
            f_way      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_tag   <= req_addr[ADDR_W-1 -: TAG_W];
                        lat_idx   <= req_addr[OFF_W +: IDX_W];
                        lat_write <= (req_op == 8'h77) || (req_op == 8'h57);
                        lat_wp    <= write_policy;
                        lat_rp    <= replace_policy;
                    end
                end
                S_LOOKUP: begin
                    if (lat_write) writes <= sat_inc(writes);
                    else           reads  <= sat_inc(reads);
                    if (hit_any)   hits   <= sat_inc(hits);
                    else           misses <= sat_inc(misses);
                    lat_hit <= hit_any;
                    lat_way <= hit_any ? hit_way : victim_way;
                    if (hit_any && lat_write && lat_wp) dirty_mem[lat_idx][hit_way] <= 1'b1;
                end
                S_WB: begin
                    if (nl_ready) writebacks <= sat_inc(writebacks);
                end
                S_FILL: begin
                    if (nl_ready) begin
                        valid_mem[lat_idx][lat_way] <= 1'b1;
                        dirty_mem[lat_idx][lat_way] <= lat_write;
                    end
                end
                default: ;
            endcase

            if (do_touch) begin
                for (int j = 0; j < ASSOC; j++) begin
                    if (WAY_W'(j) == touch_way)
                        age_mem[lat_idx][j] <= '0;
                    else if (age_mem[lat_idx][j] < touch_ref)
                        age_mem[lat_idx][j] <= age_mem[lat_idx][j] + AGE_W'(1);
                end
            end

`ifdef CACHE_FLUSH_EN
            if (flush_step) begin
                if (state == S_FLUSH_WB) writebacks <= sat_inc(writebacks);
                valid_mem[f_set][f_way] <= 1'b0;
                dirty_mem[f_set][f_way] <= 1'b0;
                age_mem[f_set][f_way]   <= '0;
                if (f_way == WAY_W'(ASSOC - 1)) begin
                    f_way <= '0;
                    f_set <= f_set + IDX_W'(1);
                end else begin
                    f_way <= f_way + WAY_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cache_level_ctrl.sv
// tb_cache_level_ctrl: directed self-checking bench for cache_level_ctrl
// (NUM_SETS=4, ASSOC=2, BLOCK_BYTES=16). A second instance with CNT_W=4
// shares all inputs and is used for the counter saturation check.
module tb_cache_level_ctrl;

    localparam int AW = 16;

    logic          clk;
    logic          reset;
    logic          write_policy;
    logic          replace_policy;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_op;
    logic          nl_ready;

    logic          req_ready, resp_valid, resp_hit, nl_valid, nl_write;
    logic [AW-1:0] nl_addr;
    logic [17:0]   reads, writes, hits, misses, writebacks;

    logic          s_req_ready, s_resp_valid, s_resp_hit, s_nl_valid, s_nl_write;
    logic [AW-1:0] s_nl_addr;
    logic [3:0]    s_reads, s_writes, s_hits, s_misses, s_writebacks;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int            last_lat;
    logic          last_hit;
    int            nl_n;
    logic [AW-1:0] nl_log_addr [16];
    logic          nl_log_wr   [16];

    cache_level_ctrl #(.ADDR_W(AW), .NUM_SETS(4), .ASSOC(2), .BLOCK_BYTES(16), .CNT_W(18)) dut (
        .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .nl_valid(nl_valid), .nl_ready(nl_ready),
        .nl_addr(nl_addr), .nl_write(nl_write), .reads(reads), .writes(writes), .hits(hits),
        .misses(misses), .writebacks(writebacks)
    );

    cache_level_ctrl #(.ADDR_W(AW), .NUM_SETS(4), .ASSOC(2), .BLOCK_BYTES(16), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_addr(req_addr), .req_op(req_op),
        .resp_valid(s_resp_valid), .resp_hit(s_resp_hit), .nl_valid(s_nl_valid), .nl_ready(nl_ready),
        .nl_addr(s_nl_addr), .nl_write(s_nl_write), .reads(s_reads), .writes(s_writes), .hits(s_hits),
        .misses(s_misses), .writebacks(s_writebacks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every accepted next-level transaction (sampled mid-cycle)
    always @(negedge clk) begin
        if (reset && nl_valid && nl_ready && nl_n < 16) begin
            nl_log_addr[nl_n] = nl_addr;
            nl_log_wr[nl_n]   = nl_write;
            nl_n++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        nl_n = 0;
    endtask

    // One request; returns at the negedge where resp_valid was seen
    task automatic do_req(input logic [AW-1:0] addr, input logic [7:0] op);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_op    = op;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_op    = 8'h77;
        n = 1;
        @(negedge clk);
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        last_lat = n;
        last_hit = resp_hit;
        check("resp_seen", resp_valid, 1);
    endtask

    initial begin
        reset = 1'b0; write_policy = 1'b0; replace_policy = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_op = 8'h72; nl_ready = 1'b1; nl_n = 0;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_nl_valid", nl_valid, 0);
        check("rst_nl_addr", nl_addr, 0);
        check("rst_reads", reads, 0);
        check("rst_hits", hits, 0);
        check("rst_misses", misses, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Cold read miss then hit in the same block
        do_req(16'h0104, 8'h72);
        check("cold_lat", last_lat, 3);
        check("cold_hit", last_hit, 0);
        check("cold_nl_n", nl_n, 1);
        check("cold_nl_addr", nl_log_addr[0], 16'h0100);
        check("cold_nl_wr", nl_log_wr[0], 0);
        check("cold_reads", reads, 1);
        check("cold_misses", misses, 1);
        do_req(16'h010C, 8'h72);
        check("hit_lat", last_lat, 2);
        check("hit_hit", last_hit, 1);
        check("hit_hits", hits, 1);
        check("hit_nl_n", nl_n, 1);
        check("hit_reads", reads, 2);

        // LRU: 0x000 re-touched, so 0x080 evicts 0x040
        pulse_reset();
        replace_policy = 1'b1;
        do_req(16'h0000, 8'h72);
        do_req(16'h0040, 8'h72);
        do_req(16'h0000, 8'h72);
        check("lru_rehit", last_hit, 1);
        do_req(16'h0080, 8'h72);
        do_req(16'h0000, 8'h72);
        check("lru_keep", last_hit, 1);
        do_req(16'h0040, 8'h72);
        check("lru_evicted", last_hit, 0);
        check("lru_hits", hits, 2);
        check("lru_misses", misses, 4);

        // FIFO: hit does not refresh, so 0x080 evicts 0x000
        pulse_reset();
        replace_policy = 1'b0;
        do_req(16'h0000, 8'h72);
        do_req(16'h0040, 8'h72);
        do_req(16'h0000, 8'h72);
        do_req(16'h0080, 8'h72);
        do_req(16'h0000, 8'h72);
        check("fifo_evicted", last_hit, 0);

        // Write-back allocate: dirty victim written back before the fill
        pulse_reset();
        write_policy = 1'b1;
        do_req(16'h0000, 8'h77);
        check("wb_alloc_lat", last_lat, 3);
        do_req(16'h0040, 8'h72);
        nl_n = 0;
        do_req(16'h0080, 8'h72);
        check("wb_lat", last_lat, 4);
        check("wb_nl_n", nl_n, 2);
        check("wb_nl0_addr", nl_log_addr[0], 16'h0000);
        check("wb_nl0_wr", nl_log_wr[0], 1);
        check("wb_nl1_addr", nl_log_addr[1], 16'h0080);
        check("wb_nl1_wr", nl_log_wr[1], 0);
        check("wb_writebacks", writebacks, 1);
        check("wb_writes", writes, 1);
        check("wb_reads", reads, 2);

        // Write-through no-allocate
        pulse_reset();
        write_policy = 1'b0;
        do_req(16'h0200, 8'h57);
        check("wt_lat", last_lat, 3);
        check("wt_hit", last_hit, 0);
        check("wt_nl_n", nl_n, 1);
        check("wt_nl_addr", nl_log_addr[0], 16'h0200);
        check("wt_nl_wr", nl_log_wr[0], 1);
        check("wt_misses", misses, 1);
        check("wt_writes", writes, 1);
        do_req(16'h0200, 8'h72);
        check("wt_rd_hit", last_hit, 0);
        check("wt_rd_nl_n", nl_n, 2);
        check("wt_rd_nl_addr", nl_log_addr[1], 16'h0200);
        check("wt_rd_nl_wr", nl_log_wr[1], 0);

        // Stalled fill, then reset in the middle of it
        pulse_reset();
        do_req(16'h0000, 8'h72);
        @(posedge clk); #1;
        nl_ready  = 1'b0;
        req_valid = 1'b1;
        req_addr  = 16'h0340;
        req_op    = 8'h72;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_nl_valid", nl_valid, 1);
            check("stall_nl_addr", nl_addr, 16'h0340);
            check("stall_nl_wr", nl_write, 0);
            check("stall_req_ready", req_ready, 0);
        end
        check("stall_reads", reads, 2);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_nl_valid", nl_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_reads", reads, 0);
        check("midrst_hits", hits, 0);
        check("midrst_misses", misses, 0);
        @(posedge clk); #1;
        reset    = 1'b1;
        nl_ready = 1'b1;
        do_req(16'h0000, 8'h72);
        check("midrst_line_gone", last_hit, 0);

        // Counter saturation (CNT_W=4 instance) versus wide instance
        pulse_reset();
        for (int i = 0; i < 20; i++) do_req(16'h0000, 8'h72);
        check("sat_reads", s_reads, 15);
        check("sat_hits", s_hits, 15);
        check("sat_misses", s_misses, 1);
        check("wide_reads", reads, 20);
        check("wide_hits", hits, 19);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_level_ctrl.md
Name: cache_level_ctrl

Overview:
- Parametrised single-level, set-associative, tag-only cache controller. It is the reusable building block for the L1/L2 hierarchy; one instance is used per level.
- Accepts address/op requests through a valid/ready handshake and performs tag lookup.
- Services misses, write-throughs and dirty writebacks through a next-level (nl_*) handshake.
- Keeps saturating hit/miss/read/write/writeback counters.

Parameters:
- ADDR_W, 48, request address width
- NUM_SETS, 64, number of sets (power of 2, >=2)
- ASSOC, 4, ways per set (power of 2, >=1)
- BLOCK_BYTES, 64, line size in bytes (power of 2)
- CNT_W, 18, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- write_policy  in  1  0 = write-through no-allocate, 1 = write-back write-allocate
- replace_policy  in  1  0 = FIFO, 1 = LRU
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_W  byte address
- req_op  in  8  ASCII op: 8'h77/8'h57 ('w'/'W') = write; any other value = read
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  lookup result, valid with resp_valid
- nl_valid  out  1  next-level request
- nl_ready  in  1  next-level accept
- nl_addr  out  ADDR_W  block-aligned next-level address
- nl_write  out  1  1 = write/writeback, 0 = fill read
- reads, writes, hits, misses, writebacks  out  CNT_W each  statistics

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid/dirty bits cleared, ages = 0, FSM = IDLE
  - all counters = 0; req_ready=1, resp_valid=0, nl_valid=0, nl_addr=0
  - applies mid-transaction: any pending nl request is abandoned.
- Address split: offset = log2(BLOCK_BYTES) LSBs; index = next log2(NUM_SETS) bits; tag = the remaining bits. nl_addr always has offset bits = 0.
- Sampling: the request is accepted when req_valid & req_ready (IDLE only). req_addr, req_op and both policy inputs are latched at acceptance; later changes have no effect until the next request.
- FSM states: IDLE, LOOKUP, WB, FILL, WT, RESP.
  - IDLE: req_ready=1. On accept, go to LOOKUP.
  - LOOKUP (one cycle): compare all ways. Increment reads or writes. Increment hits or misses.
    - Read hit, or write hit with write_policy=1: update replacement state, set dirty on a write-back write, go to RESP.
    - Write with write_policy=0: go to WT. A hit updates replacement state; a miss allocates nothing.
    - Read miss, or write miss with write_policy=1: choose a victim. If the victim is valid and dirty, go to WB; otherwise go to FILL.
  - WB: nl_valid=1, nl_write=1, nl_addr = victim tag/index. Hold until nl_ready, then increment writebacks and go to FILL.
  - FILL: nl_valid=1, nl_write=0, nl_addr = request block. On nl_ready, install the line (valid=1; dirty=1 if write else 0), update replacement state, go to RESP.
  - WT: nl_valid=1, nl_write=1, nl_addr = request block. On nl_ready, go to RESP.
  - RESP: resp_valid=1 for one cycle, resp_hit = LOOKUP result, go to IDLE.
- nl handshake: nl_addr and nl_write stay stable while nl_valid=1 && nl_ready=0. nl_valid deasserts in the cycle after acceptance.
- Latency:
  - hit: resp_valid 2 cycles after acceptance
  - clean miss with nl_ready tied high: 3 cycles
  - dirty miss: 4 cycles
  - req_ready=0 from LOOKUP through RESP; no back-to-back acceptance (next accept at the earliest 1 cycle after RESP).
- Replacement: per-way age of log2(ASSOC) bits.
  - Victim: the lowest-index invalid way; otherwise the way with age = ASSOC-1.
  - On install, the installed way gets age 0 and every way with a smaller age increments.
  - LRU also performs the same update on every hit. FIFO does not update on hits.
  - ASSOC=1: always way 0.
- Counters saturate at 2^CNT_W-1 and do not wrap.

Optional Feature:
- CACHE_FLUSH_EN defined:
  - adds input flush_req and output flush_done (1 bit each)
  - flush_req sampled in IDLE only; it has priority over a simultaneous req_valid
  - walks set 0..NUM_SETS-1, way 0..ASSOC-1; each valid dirty line issues a WB handshake (writebacks increments)
  - every line is invalidated and ages cleared
  - flush_done pulses one cycle when the walk ends; req_ready=0 during the flush
- CACHE_FLUSH_EN undefined: the ports and flush logic are absent.

Test Plan (NUM_SETS=4, ASSOC=2, BLOCK_BYTES=16, CNT_W=18 unless stated; set 0 = addresses 0x000/0x040/0x080):
- Read 0x104 cold, nl_ready=1 -> nl read at 0x100, resp_hit=0, reads=1, misses=1. Read 0x10C again -> resp_hit=1 two cycles after accept, hits=1, no nl traffic.
- replace_policy=1, reads 0x000, 0x040, 0x000, 0x080, then 0x000 -> final read hits; read 0x040 then misses. Repeat with replace_policy=0 -> final 0x000 misses.
- write_policy=1: write 0x000, read 0x040, read 0x080 -> nl write at 0x000 precedes nl read at 0x080; writebacks=1, writes=1, reads=2.
- write_policy=0: write 0x200 miss -> single nl write at 0x200, no fill, misses=1. Then read 0x200 -> miss with fill.
- Hold nl_ready=0 for 5 cycles during a FILL -> nl_valid/nl_addr stable, req_ready=0. Drive reset=0 mid-wait -> nl_valid=0 immediately, all counters 0, the previously cached line misses afterwards.
- CNT_W=4, 20 reads of 0x000 -> reads=15, hits=15, misses=1.
